// File: rtl/seq_arb_burst_requester_pkg.sv
// Shared definitions for the round-robin grant-hold arbiter and its requester agents.
package seq_arb_burst_requester_pkg;

  localparam int NUM_REQS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } req_state_e;

endpackage

// File: rtl/seq_arb_burst_requester.sv
// Requester agent: takes one burst command, wins an arbiter lane, holds it
// until every beat has been transferred, and emits base+index beats.
module seq_arb_burst_requester
  import seq_arb_burst_requester_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_val,
  output logic              cmd_rdy,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              req,
  output logic              hold,
  input  logic              grant,
  output logic              out_val,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  req_state_e        state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic              is_last;

  assign is_last  = (count_q == len_q - LEN_W'(1));
  assign out_val  = req & grant;
  assign out_last = out_val & is_last;
  assign out_data = base_q + DATA_W'(count_q);

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    base_d  = base_q;
    cmd_rdy = 1'b0;
    req     = 1'b0;
    hold    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          len_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          base_d  = cmd_data;
          count_d = '0;
          state_d = REQ;
        end
      end
      REQ, BURST: begin
        // hold only once the lane is ours, so the first cycle lets the arbiter choose
        req  = 1'b1;
        hold = (state_q == BURST);
        if (grant) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            count_d = count_q + LEN_W'(1);
            state_d = BURST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_seq_arb_burst_requester.sv
// Bench: four requesters on a behavioural round-robin grant-hold arbiter, lane 0
// checked every cycle against a beat-queue reference model.
module tb_seq_arb_burst_requester;
  import seq_arb_burst_requester_pkg::*;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REQS-1:0] cmd_val, cmd_rdy, req, hold, grant, out_val, out_last;
  logic [LEN_W-1:0]    cmd_len  [NUM_REQS];
  logic [DATA_W-1:0]   cmd_data [NUM_REQS];
  logic [DATA_W-1:0]   out_data [NUM_REQS];
  logic                use_arb;
  logic [NUM_REQS-1:0] gmask, arb_gnt;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_lane
    seq_arb_burst_requester #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_val  (cmd_val[g]),
      .cmd_rdy  (cmd_rdy[g]),
      .cmd_len  (cmd_len[g]),
      .cmd_data (cmd_data[g]),
      .req      (req[g]),
      .hold     (hold[g]),
      .grant    (grant[g]),
      .out_val  (out_val[g]),
      .out_data (out_data[g]),
      .out_last (out_last[g])
    );
  end

  assign grant = use_arb ? arb_gnt : gmask;

  // Behavioural arbiter: the last winner keeps the lane while it holds, otherwise round-robin.
  int owner;
  int ptr;

  function automatic logic [NUM_REQS-1:0] rr_pick(input logic [NUM_REQS-1:0] r, input int p);
    logic [NUM_REQS-1:0] gv;
    gv = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (gv == '0 && r[(p + k) % NUM_REQS]) gv[(p + k) % NUM_REQS] = 1'b1;
    end
    return gv;
  endfunction

  always_comb begin
    arb_gnt = '0;
    if (owner >= 0 && owner < NUM_REQS && req[owner] && hold[owner]) arb_gnt[owner] = 1'b1;
    else arb_gnt = rr_pick(req, ptr);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= -1;
      ptr   <= 0;
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        if (arb_gnt[k]) begin
          owner <= k;
          ptr   <= (k + 1) % NUM_REQS;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane-0 reference: an accepted command becomes a queue of pending beats.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t q[$];
  bit    busy  = 1'b0;
  bit    first = 1'b0;
  int    mdl_n;
  logic  e_val;

  always @(negedge clk) begin
    if (mon_en) begin
      if (!reset) begin
        q.delete();
        busy  = 1'b0;
        first = 1'b0;
      end
      e_val = busy && grant[0];
      check("m_rdy",  {31'd0, cmd_rdy[0]}, {31'd0, !busy});
      check("m_req",  {31'd0, req[0]},     {31'd0, busy});
      check("m_hold", {31'd0, hold[0]},    {31'd0, busy && !first});
      check("m_val",  {31'd0, out_val[0]}, {31'd0, e_val});
      if (e_val) begin
        check("m_data", {24'd0, out_data[0]}, {24'd0, q[0].data});
        check("m_last", {31'd0, out_last[0]}, {31'd0, q[0].last});
      end else begin
        check("m_last0", {31'd0, out_last[0]}, 32'd0);
      end
      if (reset) begin
        if (e_val) begin
          first = 1'b0;
          if (q[0].last) busy = 1'b0;
          void'(q.pop_front());
        end else if (!busy && cmd_val[0]) begin
          mdl_n = (cmd_len[0] == '0) ? 1 : int'(cmd_len[0]);
          for (int i = 0; i < mdl_n; i++)
            q.push_back('{data: cmd_data[0] + DATA_W'(i), last: (i == mdl_n - 1)});
          busy  = 1'b1;
          first = 1'b1;
        end
      end
    end
  end

  // Called at posedge+1; leaves the command accepted and the bench in the REQ cycle.
  task automatic send_cmd(input int l, input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] d);
    cmd_val[l]  = 1'b1;
    cmd_len[l]  = len;
    cmd_data[l] = d;
    @(posedge clk); #1;
    cmd_val[l] = 1'b0;
  endtask

  task automatic expect_burst(input int l, input int n, input logic [DATA_W-1:0] base, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s_val%0d", tag, i),  {31'd0, out_val[l]},  32'd1);
      check($sformatf("%s_data%0d", tag, i), {24'd0, out_data[l]}, {24'd0, base + DATA_W'(i)});
      check($sformatf("%s_hold%0d", tag, i), {31'd0, hold[l]},     {31'd0, i > 0});
      check($sformatf("%s_last%0d", tag, i), {31'd0, out_last[l]}, {31'd0, i == n - 1});
      @(posedge clk); #1;
    end
  endtask

  int beats;
  logic [NUM_REQS-1:0] exp_g [5];
  logic [DATA_W-1:0]   exp_d [5];

  initial begin
    reset   = 1'b0;
    cmd_val = '0;
    gmask   = 4'hF;
    use_arb = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cmd_len[i]  = '0;
      cmd_data[i] = '0;
    end
    mon_en = 1'b1;

    #12;
    check("rst_rdy",  {28'd0, cmd_rdy},  32'hF);
    check("rst_req",  {28'd0, req},      32'h0);
    check("rst_hold", {28'd0, hold},     32'h0);
    check("rst_val",  {28'd0, out_val},  32'h0);
    check("rst_last", {28'd0, out_last}, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_gnt_ignored", {28'd0, out_val}, 32'h0);

    send_cmd(0, 4'd1, 8'h10);
    expect_burst(0, 1, 8'h10, "single");
    @(negedge clk);
    check("single_rdy_after", {31'd0, cmd_rdy[0]}, 32'd1);
    @(posedge clk); #1;

    send_cmd(0, 4'd4, 8'hFE);
    expect_burst(0, 4, 8'hFE, "b4");
    @(negedge clk);
    check("b4_rdy_after", {31'd0, cmd_rdy[0]}, 32'd1);
    @(posedge clk); #1;

    send_cmd(0, 4'd0, 8'h77);
    beats = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_val[0]) beats++;
      @(posedge clk); #1;
    end
    check("len0_beats", beats, 32'd1);

    send_cmd(0, 4'd5, 8'h30);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        gmask[0] = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("stall_val",  {31'd0, out_val[0]}, 32'd0);
          check("stall_req",  {31'd0, req[0]},     32'd1);
          check("stall_hold", {31'd0, hold[0]},    32'd1);
          @(posedge clk); #1;
        end
        gmask[0] = 1'b1;
      end
      @(negedge clk);
      check($sformatf("stall_data%0d", i), {24'd0, out_data[0]}, {24'd0, 8'h30 + 8'(i)});
      check($sformatf("stall_last%0d", i), {31'd0, out_last[0]}, {31'd0, i == 4});
      @(posedge clk); #1;
    end

    send_cmd(0, 4'd5, 8'hA0);
    repeat (2) @(posedge clk);
    #1;
    check("rb_pre_data", {24'd0, out_data[0]}, 32'hA2);
    #2 reset = 1'b0;
    #1;
    check("rb_val",  {31'd0, out_val[0]},  32'd0);
    check("rb_req",  {31'd0, req[0]},      32'd0);
    check("rb_hold", {31'd0, hold[0]},     32'd0);
    check("rb_last", {31'd0, out_last[0]}, 32'd0);
    check("rb_rdy",  {31'd0, cmd_rdy[0]},  32'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check("rb_rdy_release", {31'd0, cmd_rdy[0]}, 32'd1);
    send_cmd(0, 4'd2, 8'hC0);
    expect_burst(0, 2, 8'hC0, "post_rst");

    // Lane 1 (len 3) wins first; lane 2 (len 2) arrives mid-burst and must wait.
    gmask   = '0;
    use_arb = 1'b1;
    exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100};
    exp_d = '{8'h40, 8'h41, 8'h42, 8'h50, 8'h51};
    send_cmd(1, 4'd3, 8'h40);
    cmd_val[2]  = 1'b1;
    cmd_len[2]  = 4'd2;
    cmd_data[2] = 8'h50;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("arb_gnt%0d", k), {28'd0, grant}, {28'd0, exp_g[k]});
      check($sformatf("arb_val%0d", k), {28'd0, out_val}, {28'd0, exp_g[k]});
      check($sformatf("arb_data%0d", k), {24'd0, (k < 3) ? out_data[1] : out_data[2]}, {24'd0, exp_d[k]});
      check($sformatf("arb_last%0d", k), {28'd0, out_last},
            (k == 2) ? 32'b0010 : (k == 4) ? 32'b0100 : 32'd0);
      @(posedge clk); #1;
      cmd_val[2] = 1'b0;
    end

    // Random commands and grants on lane 0 against the model.
    use_arb = 1'b0;
    for (int c = 0; c < 400; c++) begin
      gmask[0]    = ($urandom_range(0, 3) != 0);
      cmd_val[0]  = ($urandom_range(0, 2) == 0);
      cmd_len[0]  = LEN_W'($urandom);
      cmd_data[0] = DATA_W'($urandom);
      @(posedge clk); #1;
    end
    cmd_val[0] = 1'b0;
    gmask[0]   = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Random traffic on all four lanes through the arbiter.
    use_arb = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int l = 0; l < NUM_REQS; l++) begin
        cmd_val[l]  = ($urandom_range(0, 3) == 0);
        cmd_len[l]  = LEN_W'($urandom);
        cmd_data[l] = DATA_W'($urandom);
      end
      @(negedge clk);
      check("arb_onehot", {31'd0, $countones(grant) <= 1}, 32'd1);
      check("arb_val_eq_gnt", {28'd0, out_val}, {28'd0, grant & req});
      @(posedge clk); #1;
    end
    cmd_val = '0;
    repeat (60) @(posedge clk);
    #1;
    check("drain_idle", {28'd0, cmd_rdy}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
